// File: rtl/screen_fetch.sv
// Hack screen fetcher: one VRAM word per 16 pixels, serialised LSB-first.
// Define SCREEN_FETCH_UNDERRUN_EN to enable the sticky underrun flag.
module screen_fetch #(
    parameter int X0        = 64,
    parameter int Y0        = 112,
    parameter int FETCH_LAT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        line_start,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        de,
    output logic        p_read,
    output logic [12:0] p_addr,
    input  logic [15:0] p_dout,
    output logic        pixel,
    output logic        pixel_valid,
    output logic        underrun
);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

    state_t state, state_d;

    logic [7:0]           row;
    logic [4:0]           col;
    logic                 last;
    logic [FETCH_LAT-1:0] dl;
    logic [15:0]          next_word;
    logic [15:0]          sh;
    logic [15:0]          word;
    logic                 next_valid;
    logic                 drop;
    logic [12:0]          addr_q;
    logic [10:0]          xoff;
    logic [10:0]          yoff;
    logic                 x_in;
    logic                 y_in;
    logic                 load;
    logic                 late;
    logic                 cap;
    logic                 at_end;
    logic                 show;

    assign xoff   = {1'b0, pix_x} - 11'(X0);
    assign yoff   = {1'b0, pix_y} - 11'(Y0);
    assign x_in   = xoff < 11'd512;
    assign y_in   = yoff < 11'd256;
    assign load   = (state == STREAM) && de && x_in && !last &&
                    !line_start && (xoff[8:0] == {col, 4'b0});
    assign late   = load && !next_valid;
    assign cap    = dl[FETCH_LAT-1];
    assign word   = next_valid ? next_word : 16'h0000;
    assign at_end = de && x_in && (xoff[8:0] == 9'd511);
    assign show   = (state == STREAM) && de && x_in && y_in;

    always_comb begin
        state_d = state;
        p_read  = 1'b0;
        p_addr  = addr_q;
        unique case (state)
            IDLE: begin
                if (line_start && y_in) state_d = PRIME;
            end
            PRIME: begin
                if (line_start) begin
                    state_d = y_in ? PRIME : IDLE;
                end else begin
                    p_read  = 1'b1;
                    p_addr  = {row, 5'd0};
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (line_start) begin
                    state_d = y_in ? PRIME : IDLE;
                end else if (load) begin
                    if (col != 5'd31) begin
                        p_read = 1'b1;
                        p_addr = {row, col + 5'd1};
                    end
                end else if (last && at_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            row         <= '0;
            col         <= '0;
            last        <= 1'b0;
            dl          <= '0;
            next_word   <= '0;
            next_valid  <= 1'b0;
            drop        <= 1'b0;
            sh          <= '0;
            pixel       <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            state       <= state_d;
            addr_q      <= p_addr;
            pixel_valid <= de && x_in && y_in;
            if (load) begin
                pixel <= show & word[0];
                sh    <= {1'b0, word[15:1]};
            end else begin
                pixel <= show & sh[0];
                sh    <= {1'b0, sh[15:1]};
            end
            if (line_start) begin
                dl         <= '0;
                next_valid <= 1'b0;
                drop       <= 1'b0;
                if (y_in) begin
                    row  <= yoff[7:0];
                    col  <= '0;
                    last <= 1'b0;
                end
            end else begin
                dl <= {dl[FETCH_LAT-2:0], p_read};
                if (load) begin
                    last <= (col == 5'd31);
                    if (col != 5'd31) col <= col + 5'd1;
                end
                // A word that missed its slot is discarded when it lands
                if (cap && drop) begin
                    drop <= late && |dl[FETCH_LAT-2:0];
                    if (load) next_valid <= 1'b0;
                end else if (cap && !late) begin
                    next_word  <= p_dout;
                    next_valid <= 1'b1;
                end else if (load) begin
                    next_valid <= 1'b0;
                    if (late && !cap) drop <= |dl;
                end
            end
        end
    end

`ifdef SCREEN_FETCH_UNDERRUN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) underrun <= 1'b0;
        else if (late) underrun <= 1'b1;
    end
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_screen_fetch.sv
// Directed bench for screen_fetch: fast (lat 3) and slow (lat 20) VRAM.
// Underrun expectation follows SCREEN_FETCH_UNDERRUN_EN.
module tb_screen_fetch;

    localparam int X0 = 64;
    localparam int Y0 = 112;
    localparam int H  = 600;
`ifdef SCREEN_FETCH_UNDERRUN_EN
    localparam logic UR = 1'b1;
`else
    localparam logic UR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        line_start = 1'b0;
    logic        de = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        p_read, pixel, pixel_valid, underrun;
    logic [12:0] p_addr;
    logic [15:0] p_dout;
    logic        p_read_s, pixel_s, pixel_valid_s, underrun_s;
    logic [12:0] p_addr_s;
    logic [15:0] p_dout_s;

    logic [15:0] mem [8192];
    logic [12:0] sa_f [3];
    logic [12:0] sa_s [20];

    int          vectors = 0;
    int          miscompares = 0;
    bit          sel = 1'b0;
    int          nreads;
    logic [12:0] addrs [$];
    logic        pix_o [H];
    logic        pv_o [H];

    always #5 clk = ~clk;

    screen_fetch #(.X0(X0), .Y0(Y0), .FETCH_LAT(3)) dut (
        .clk(clk), .reset_n(reset_n), .line_start(line_start),
        .pix_x(pix_x), .pix_y(pix_y), .de(de),
        .p_read(p_read), .p_addr(p_addr), .p_dout(p_dout),
        .pixel(pixel), .pixel_valid(pixel_valid), .underrun(underrun)
    );

    screen_fetch #(.X0(X0), .Y0(Y0), .FETCH_LAT(20)) dut_slow (
        .clk(clk), .reset_n(reset_n), .line_start(line_start),
        .pix_x(pix_x), .pix_y(pix_y), .de(de),
        .p_read(p_read_s), .p_addr(p_addr_s), .p_dout(p_dout_s),
        .pixel(pixel_s), .pixel_valid(pixel_valid_s),
        .underrun(underrun_s)
    );

    // VRAM models: data for a read sampled at edge E is stable before E+LAT
    always @(posedge clk) begin
        sa_f[0] <= p_addr;
        for (int i = 1; i < 3; i++) sa_f[i] <= sa_f[i-1];
        sa_s[0] <= p_addr_s;
        for (int i = 1; i < 20; i++) sa_s[i] <= sa_s[i-1];
    end
    assign p_dout   = mem[sa_f[2]];
    assign p_dout_s = mem[sa_s[19]];

    function automatic logic exp_pix(input int y, input int x);
        int k, b;
        logic [15:0] w;
        if (y < Y0 || y >= Y0 + 256) return 1'b0;
        if (x < X0 || x >= X0 + 512) return 1'b0;
        k = (x - X0) / 16;
        b = (x - X0) % 16;
        w = mem[(y - Y0) * 32 + k];
        return w[b];
    endfunction

    function automatic logic exp_pv(input int y, input int x);
        return (y >= Y0 && y < Y0 + 256 && x >= X0 && x < X0 + 512);
    endfunction

    task automatic run_line(input int y, input int stop_x, input bit ls);
        nreads = 0;
        addrs.delete();
        for (int x = 0; x < H; x++) begin
            pix_o[x] = 1'b0;
            pv_o[x]  = 1'b0;
        end
        for (int x = 0; x < stop_x; x++) begin
            @(negedge clk);
            if (x > 0) begin
                pix_o[x-1] = sel ? pixel_s : pixel;
                pv_o[x-1]  = sel ? pixel_valid_s : pixel_valid;
            end
            pix_x      = 10'(x);
            pix_y      = 10'(y);
            de         = (x >= X0 && x < X0 + 512);
            line_start = ls && (x == 0);
            #1;
            if (sel ? p_read_s : p_read) begin
                nreads++;
                addrs.push_back(sel ? p_addr_s : p_addr);
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (p_read !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_p_read got %b want 0", p_read);
        end
        vectors++;
        if (p_addr !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_p_addr got %0d want 0", p_addr);
        end
        vectors++;
        if (pixel !== 1'b0 || pixel_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pixel got %b%b want 00", pixel, pixel_valid);
        end
        vectors++;
        if (underrun !== 1'b0 || underrun_s !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_underrun got %b%b want 00",
                     underrun, underrun_s);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_row0;
        int ones;
        sel = 1'b0;
        run_line(Y0, H, 1'b1);
        vectors++;
        if (nreads !== 32) begin
            miscompares++;
            $display("FAIL row0_reads got %0d want 32", nreads);
        end
        for (int i = 0; i < nreads && i < 32; i++) begin
            vectors++;
            if (addrs[i] !== 13'(i)) begin
                miscompares++;
                $display("FAIL row0_addr[%0d] got %0d want %0d",
                         i, addrs[i], i);
            end
        end
        ones = 0;
        for (int x = 0; x < H - 1; x++) if (pix_o[x] === 1'b1) ones++;
        vectors++;
        if (ones !== 2 || pix_o[X0] !== 1'b1 || pix_o[X0+31] !== 1'b1) begin
            miscompares++;
            $display("FAIL row0_ones got %0d (x0=%b x31=%b) want 2 (1,1)",
                     ones, pix_o[X0], pix_o[X0+31]);
        end
        for (int x = 0; x < H - 1; x++) begin
            vectors++;
            if (pv_o[x] !== exp_pv(Y0, x)) begin
                miscompares++;
                $display("FAIL row0_pv x=%0d got %b want %b",
                         x, pv_o[x], exp_pv(Y0, x));
            end
        end
    endtask

    task automatic test_last_row;
        sel = 1'b0;
        run_line(Y0 + 255, H, 1'b1);
        vectors++;
        if (nreads !== 32) begin
            miscompares++;
            $display("FAIL last_reads got %0d want 32", nreads);
        end
        for (int i = 0; i < nreads && i < 32; i++) begin
            vectors++;
            if (addrs[i] !== 13'(8160 + i)) begin
                miscompares++;
                $display("FAIL last_addr[%0d] got %0d want %0d",
                         i, addrs[i], 8160 + i);
            end
        end
        for (int x = 0; x < H - 1; x++) begin
            vectors++;
            if (pix_o[x] !== exp_pix(Y0 + 255, x) ||
                pv_o[x] !== exp_pv(Y0 + 255, x)) begin
                miscompares++;
                $display("FAIL last_pix x=%0d got %b%b want %b%b", x,
                         pix_o[x], pv_o[x], exp_pix(Y0 + 255, x),
                         exp_pv(Y0 + 255, x));
            end
        end
    endtask

    task automatic test_outside;
        int ys [2];
        int lit;
        ys[0] = Y0 + 256;
        ys[1] = Y0 - 1;
        sel = 1'b0;
        for (int j = 0; j < 2; j++) begin
            run_line(ys[j], H, 1'b1);
            vectors++;
            if (nreads !== 0) begin
                miscompares++;
                $display("FAIL out_reads y=%0d got %0d want 0", ys[j], nreads);
            end
            lit = 0;
            for (int x = 0; x < H - 1; x++)
                if (pv_o[x] !== 1'b0 || pix_o[x] !== 1'b0) lit++;
            vectors++;
            if (lit !== 0) begin
                miscompares++;
                $display("FAIL out_pixels y=%0d got %0d lit want 0", ys[j], lit);
            end
        end
    endtask

    task automatic test_abort;
        sel = 1'b0;
        run_line(Y0 + 5, X0 + 161, 1'b1);
        vectors++;
        if (nreads !== 12) begin
            miscompares++;
            $display("FAIL abort_partial_reads got %0d want 12", nreads);
        end
        run_line(Y0 + 9, H, 1'b1);
        vectors++;
        if (nreads !== 32) begin
            miscompares++;
            $display("FAIL abort_reads got %0d want 32", nreads);
        end
        for (int i = 0; i < nreads && i < 32; i++) begin
            vectors++;
            if (addrs[i] !== 13'(288 + i)) begin
                miscompares++;
                $display("FAIL abort_addr[%0d] got %0d want %0d",
                         i, addrs[i], 288 + i);
            end
        end
        for (int x = 0; x < H - 1; x++) begin
            vectors++;
            if (pix_o[x] !== exp_pix(Y0 + 9, x)) begin
                miscompares++;
                $display("FAIL abort_pix x=%0d got %b want %b",
                         x, pix_o[x], exp_pix(Y0 + 9, x));
            end
        end
    endtask

    task automatic test_reset_mid;
        int lit;
        sel = 1'b0;
        run_line(Y0 + 3, X0 + 100, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (p_read !== 1'b0 || pixel !== 1'b0 ||
            pixel_valid !== 1'b0 || underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_out got %b%b%b%b want 0000",
                     p_read, pixel, pixel_valid, underrun);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_line(Y0 + 3, H, 1'b0);
        vectors++;
        if (nreads !== 0) begin
            miscompares++;
            $display("FAIL midreset_reads got %0d want 0", nreads);
        end
        lit = 0;
        for (int x = 0; x < H - 1; x++) if (pix_o[x] !== 1'b0) lit++;
        vectors++;
        if (lit !== 0) begin
            miscompares++;
            $display("FAIL midreset_pix got %0d lit want 0", lit);
        end
        run_line(Y0 + 4, H, 1'b1);
        vectors++;
        if (nreads !== 32 || addrs[0] !== 13'd128) begin
            miscompares++;
            $display("FAIL midreset_resume got %0d reads want 32", nreads);
        end
    endtask

    task automatic test_underrun;
        logic e;
        sel = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        vectors++;
        if (underrun_s !== 1'b0) begin
            miscompares++;
            $display("FAIL ur_init got %b want 0", underrun_s);
        end
        run_line(Y0 + 7, H, 1'b1);
        vectors++;
        if (nreads !== 32) begin
            miscompares++;
            $display("FAIL ur_reads got %0d want 32", nreads);
        end
        for (int x = 0; x < H - 1; x++) begin
            e = (x < X0 + 16) ? exp_pix(Y0 + 7, x) : 1'b0;
            vectors++;
            if (pix_o[x] !== e || pv_o[x] !== exp_pv(Y0 + 7, x)) begin
                miscompares++;
                $display("FAIL ur_pix x=%0d got %b%b want %b%b", x,
                         pix_o[x], pv_o[x], e, exp_pv(Y0 + 7, x));
            end
        end
        vectors++;
        if (underrun_s !== UR) begin
            miscompares++;
            $display("FAIL ur_flag got %b want %b", underrun_s, UR);
        end
        vectors++;
        if (underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ur_fast_flag got %b want 0", underrun);
        end
        run_line(Y0 + 8, H, 1'b1);
        run_line(Y0 - 1, H, 1'b1);
        vectors++;
        if (underrun_s !== UR) begin
            miscompares++;
            $display("FAIL ur_sticky got %b want %b", underrun_s, UR);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (underrun_s !== 1'b0) begin
            miscompares++;
            $display("FAIL ur_clear got %b want 0", underrun_s);
        end
        @(negedge clk);
        reset_n = 1'b1;
        sel = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 8192; a++)
            mem[a] = 16'((a * 40503 + 7919) ^ (a >> 3));
        mem[0] = 16'h0001;
        mem[1] = 16'h8000;
        for (int a = 2; a < 32; a++) mem[a] = 16'h0000;
        test_reset();
        test_row0();
        test_last_row();
        test_outside();
        test_abort();
        test_reset_mid();
        test_underrun();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/screen_fetch.md
# screen_fetch

Display-side consumer of the Hack screen memory: fetches 16-bit screen words from the video RAM read port (p_read/p_addr/p_dout) and serialises them into a 1-bit-per-clock pixel stream for the VGA output stage. Sits between the VGA timing generator (which supplies pix_x/pix_y/de/line_start) and the colour/encoder stage. It issues exactly one read strobe per 16 pixels, keeping the CPU-side stall (s_busy) to one cycle in sixteen during active lines.

## Interface
- X0, 64: first horizontal pixel of the 512-wide screen window.
- Y0, 112: first line of the 256-high screen window.
- FETCH_LAT, 3: clocks from the edge sampling p_read=1 to the edge where p_dout holds that word.

- clk  in  1  pixel clock, one pixel per cycle.
- reset_n  in  1  asynchronous, active-low reset.
- line_start  in  1  one-cycle pulse at start of each line's horizontal blanking; ≥ FETCH_LAT+2 cycles before pix_x==X0.
- pix_x  in  10  current pixel column from timing generator.
- pix_y  in  10  current line.
- de  in  1  display enable (active video).
- p_read  out  1  one-cycle read strobe to video RAM.
- p_addr  out  13  word address, row*32 + col.
- p_dout  in  16  read data from video RAM.
- pixel  out  1  1 = black (Hack convention).
- pixel_valid  out  1  pixel lies inside the screen window.
- underrun  out  1  sticky: a word was needed before it arrived.

## Operation
- States: IDLE, PRIME, STREAM.
- IDLE: on line_start with Y0 ≤ pix_y < Y0+256, latch row = pix_y−Y0 (8 bits), col = 0, go PRIME. Otherwise stay.
- PRIME: assert p_read for one cycle with p_addr = row*32; go STREAM.
- STREAM: a FETCH_LAT-deep delay line of p_read marks returning data; on its output, capture p_dout into next_word, set next_valid.
- Load point: de=1 and pix_x == X0+16k, k=0..31. Shift register ← next_word, next_valid ← 0; if k<31 issue p_read with p_addr = row*32+k+1 the same cycle.
- Pixel mapping: pix_x = X0+16k+b displays bit b of word k (bit 0 leftmost).
- After load k=31 and its 16 pixels, return to IDLE.
- Exactly 32 p_read pulses per window line; zero on other lines and outside STREAM/PRIME.
- Underrun: at a load point with next_valid=0, that word displays as 0 and underrun is set.
- line_start in PRIME/STREAM: abort line, clear delay line and next_valid (in-flight data discarded), re-evaluate as from IDLE.
- Outside window or de=0: pixel=0, pixel_valid=0.

## Timing
- pixel/pixel_valid registered: reflect pix_x/pix_y/de sampled one edge earlier (latency 1).
- Word k+1 request at pixel 16k; lands FETCH_LAT cycles later; needed at 16(k+1): slack 16−FETCH_LAT.
- p_addr valid only while p_read=1; holds last value otherwise.
- Reset values: p_read=0, p_addr=0, pixel=0, pixel_valid=0, underrun=0, state IDLE, next_valid=0, delay line cleared.
- Reset mid-line: all above immediately; no p_read until next qualifying line_start.
- Row arithmetic: row*32 as {row,5'b0}; col 5 bits, no wrap past 31.

## Configuration
- SCREEN_FETCH_UNDERRUN_EN defined: underrun sticky, set as above, cleared only by reset_n.
- Undefined: underrun tied 0, detection logic removed; underrun word still displays as 0.

## Test plan
- Reset mid-STREAM → next cycle p_read=0, pixel=0, pixel_valid=0, underrun=0; no reads until next window line_start.
- VRAM model (latency 3) row 0 word 0 = 16'h0001, word 1 = 16'h8000 → pixel=1 only at x=X0 and x=X0+31; 32 p_read pulses, addresses 0..31.
- Line pix_y=Y0+255 → addresses 8160..8191; line Y0+256 and Y0−1 → zero p_read pulses, pixel_valid=0.
- Bench VRAM with latency 20 (> 16) and macro defined → underrun=1 after first line, stays 1; affected words display 0.
- Same with macro undefined → underrun stays 0.
- Second line_start during STREAM at col 10 → in-flight word dropped, PRIME restarts at new row*32, no stale pixels.
